edge_pattern_gen: RTL and testbench

Synthetic ADC-sample source that drives programmable bursts of rising/falling edges into the edge-trigger datapath in place of `ADC_data`. It is the transmit-side counterpart of the edge trigger: firmware or a testbench configures levels, ramp slope, pulse/gap lengths and pulse count, then fires `start_i`. The block emits one 10-bit sample per cycle plus a marker at each completed rising edge, so trigger latency and edge counting can be measured on hardware without an analog source.

---
 rtl/edge_pkg.sv | 21 ++
 rtl/edge_gen_lfsr.sv | 19 +
 rtl/edge_pattern_gen.sv | 183 ++++++++++++++++++
 tb/tb_edge_pattern_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the edge pattern generator.
// Holds the FSM encoding, edge-type codes and LFSR constants.
package edge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL,
    S_DONE
  } state_t;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // right-shift Fibonacci taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/edge_gen_lfsr.sv
// 16-bit Fibonacci LFSR used as the sample noise source.
// Only built when EDGE_GEN_NOISE_EN is defined.
module edge_gen_lfsr
  import edge_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  always_ff @(posedge clk) begin
    if (reset_i)
      state_o <= LFSR_SEED;
    else if (en_i)
      state_o <= {^(state_o & LFSR_TAPS), state_o[15:1]};
  end

endmodule

// File: rtl/edge_pattern_gen.sv
// Synthetic ADC source emitting programmable rising/falling edge bursts.
// Optional sample noise is enabled with the EDGE_GEN_NOISE_EN macro.
module edge_pattern_gen
  import edge_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] low_level_i,
  input  logic [DATA_W-1:0] high_level_i,
  input  logic [DATA_W-1:0] ramp_step_i,
  input  logic [LEN_W-1:0]  high_len_i,
  input  logic [LEN_W-1:0]  low_len_i,
  input  logic [CNT_W-1:0]  pulse_num_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              edge_mark_o
);

  state_t            state;
  logic [DATA_W-1:0] lo_q, hi_q, step_q, smp_q;
  logic [LEN_W-1:0]  hlen_q, llen_q, len_cnt;
  logic [CNT_W-1:0]  pulse_cnt;

  logic              edge_sel;
  logic [DATA_W-1:0] tgt, ramp_nxt;
  logic [DATA_W:0]   up_sum, gap;

  function automatic logic [LEN_W-1:0] len_m1(
    input logic [LEN_W-1:0] l
  );
    return (l == '0) ? '0 : l - 1'b1;
  endfunction

  // HIGH already heads toward the low level for the first FALL sample
  always_comb begin
    edge_sel = (state == S_HIGH || state == S_FALL)
             ? EDGE_FALLING : EDGE_RISING;
    tgt      = (edge_sel == EDGE_RISING) ? hi_q : lo_q;
    up_sum   = {1'b0, smp_q} + {1'b0, step_q};
    gap      = {1'b0, smp_q} - {1'b0, tgt};
    ramp_nxt = tgt;
    if (step_q != '0) begin
      if (smp_q < tgt) begin
        if (up_sum < {1'b0, tgt})
          ramp_nxt = up_sum[DATA_W-1:0];
      end else if (smp_q > tgt) begin
        if ({1'b0, step_q} < gap)
          ramp_nxt = smp_q - step_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state        <= S_IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      step_q       <= '0;
      hlen_q       <= '0;
      llen_q       <= '0;
      len_cnt      <= '0;
      pulse_cnt    <= '0;
      smp_q        <= '0;
      data_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      edge_mark_o  <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      edge_mark_o <= 1'b0;
      if (abort_i && busy_o) begin
        state        <= S_IDLE;
        smp_q        <= lo_q;
        len_cnt      <= '0;
        pulse_cnt    <= '0;
        data_valid_o <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_DONE: begin
            state <= S_IDLE;
            if (start_i && !abort_i) begin
              lo_q   <= low_level_i;
              hi_q   <= high_level_i;
              step_q <= ramp_step_i;
              hlen_q <= high_len_i;
              llen_q <= low_len_i;
              if (pulse_num_i == '0) begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end else begin
                state        <= S_LOW;
                smp_q        <= low_level_i;
                len_cnt      <= len_m1(low_len_i);
                pulse_cnt    <= pulse_num_i;
                data_valid_o <= 1'b1;
                busy_o       <= 1'b1;
              end
            end
          end
          S_LOW: begin
            if (len_cnt != '0) begin
              len_cnt <= len_cnt - 1'b1;
            end else begin
              state       <= S_RISE;
              smp_q       <= ramp_nxt;
              edge_mark_o <= (ramp_nxt == hi_q);
            end
          end
          S_RISE: begin
            if (smp_q == hi_q) begin
              state   <= S_HIGH;
              len_cnt <= len_m1(hlen_q);
            end else begin
              smp_q       <= ramp_nxt;
              edge_mark_o <= (ramp_nxt == hi_q);
            end
          end
          S_HIGH: begin
            if (len_cnt != '0) begin
              len_cnt <= len_cnt - 1'b1;
            end else begin
              state <= S_FALL;
              smp_q <= ramp_nxt;
            end
          end
          S_FALL: begin
            if (smp_q == lo_q) begin
              pulse_cnt <= pulse_cnt - 1'b1;
              if (pulse_cnt == CNT_W'(1)) begin
                state        <= S_DONE;
                done_o       <= 1'b1;
                data_valid_o <= 1'b0;
                busy_o       <= 1'b0;
              end else begin
                state   <= S_LOW;
                len_cnt <= len_m1(llen_q);
              end
            end else begin
              smp_q <= ramp_nxt;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef EDGE_GEN_NOISE_EN
  logic [15:0]       lfsr;
  logic [DATA_W+1:0] noisy;

  edge_gen_lfsr u_lfsr (
    .clk     (clk),
    .reset_i (reset_i),
    .en_i    (data_valid_o),
    .state_o (lfsr)
  );

  // sign bit set means underflow, next bit set means overflow
  always_comb begin
    noisy = {2'b00, smp_q}
          + {{(DATA_W - 1){lfsr[2]}}, lfsr[2:0]};
    if (noisy[DATA_W+1])
      data_o = '0;
    else if (noisy[DATA_W])
      data_o = '1;
    else
      data_o = noisy[DATA_W-1:0];
  end
`else
  assign data_o = smp_q;
`endif

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Randomized self-checking bench for edge_pattern_gen.
// Expected samples come from a list-based burst model.
module tb_edge_pattern_gen;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [9:0]  low_level_i = '0;
  logic [9:0]  high_level_i = '0;
  logic [9:0]  ramp_step_i = '0;
  logic [15:0] high_len_i = '0;
  logic [15:0] low_len_i = '0;
  logic [7:0]  pulse_num_i = '0;
  logic [9:0]  data_o;
  logic        data_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        edge_mark_o;

  int total = 0;
  int bad = 0;
  int exp_d[$];
  bit exp_m[$];

  edge_pattern_gen dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .low_level_i  (low_level_i),
    .high_level_i (high_level_i),
    .ramp_step_i  (ramp_step_i),
    .high_len_i   (high_len_i),
    .low_len_i    (low_len_i),
    .pulse_num_i  (pulse_num_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .edge_mark_o  (edge_mark_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic bit near(input logic [9:0] a, input int e);
    logic [9:0] ev;
    int d;
    ev = e[9:0];
    d = int'(a) - e;
    if ($isunknown(a)) return 1'b0;
`ifdef EDGE_GEN_NOISE_EN
    return (d >= -4) && (d <= 4);
`else
    return (a == ev) && (d == 0);
`endif
  endfunction

  function automatic int step_to(input int v, input int t, input int s);
    if (s == 0) return t;
    if (v < t) return (v + s > t) ? t : v + s;
    return (v - s < t) ? t : v - s;
  endfunction

  task automatic build_model(input int lo, input int hi, input int st,
                             input int hl, input int ll, input int pn);
    int v;
    exp_d.delete();
    exp_m.delete();
    v = lo;
    for (int p = 0; p < pn; p++) begin
      for (int i = 0; i < ((ll == 0) ? 1 : ll); i++) begin
        exp_d.push_back(lo);
        exp_m.push_back(1'b0);
      end
      do begin
        v = step_to(v, hi, st);
        exp_d.push_back(v);
        exp_m.push_back(v == hi);
      end while (v != hi);
      for (int i = 0; i < ((hl == 0) ? 1 : hl); i++) begin
        exp_d.push_back(hi);
        exp_m.push_back(1'b0);
      end
      do begin
        v = step_to(v, lo, st);
        exp_d.push_back(v);
        exp_m.push_back(1'b0);
      end while (v != lo);
    end
  endtask

  task automatic drive_cfg(input int lo, input int hi, input int st,
                           input int hl, input int ll, input int pn);
    low_level_i  = lo[9:0];
    high_level_i = hi[9:0];
    ramp_step_i  = st[9:0];
    high_len_i   = hl[15:0];
    low_len_i    = ll[15:0];
    pulse_num_i  = pn[7:0];
  endtask

  task automatic poke_cfg();
    low_level_i  = 10'($urandom);
    high_level_i = 10'($urandom);
    ramp_step_i  = 10'($urandom);
    high_len_i   = 16'($urandom_range(0, 9));
    low_len_i    = 16'($urandom_range(0, 9));
    pulse_num_i  = 8'($urandom_range(0, 5));
  endtask

  // caller sits at a negedge; start is presented immediately
  task automatic run_burst(input int lo, input int hi, input int st,
                           input int hl, input int ll, input int pn,
                           input bit poke);
    build_model(lo, hi, st, hl, ll, pn);
    drive_cfg(lo, hi, st, hl, ll, pn);
    start_i = 1'b1;
    abort_i = 1'b0;
    foreach (exp_d[i]) begin
      @(negedge clk);
      start_i = 1'b0;
      if (poke) begin
        poke_cfg();
        start_i = 1'($urandom_range(0, 1));
      end
      total++;
      if (!near(data_o, exp_d[i])) begin
        bad++;
        $display("FAIL burst_data idx=%0d got=%0d want=%0d",
                 i, data_o, exp_d[i]);
      end
      total++;
      if ({data_valid_o, busy_o, done_o, edge_mark_o}
          !== {3'b110, exp_m[i]}) begin
        bad++;
        $display("FAIL burst_flags idx=%0d got=%b want=%b",
                 i, {data_valid_o, busy_o, done_o, edge_mark_o},
                 {3'b110, exp_m[i]});
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    total++;
    if ({data_valid_o, busy_o, done_o, edge_mark_o} !== 4'b0010) begin
      bad++;
      $display("FAIL done_flags got=%b want=0010",
               {data_valid_o, busy_o, done_o, edge_mark_o});
    end
    total++;
    if (!near(data_o, lo)) begin
      bad++;
      $display("FAIL done_data got=%0d want=%0d", data_o, lo);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({data_valid_o, busy_o, done_o, edge_mark_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {data_valid_o, busy_o, done_o, edge_mark_o});
    end
    total++;
    if (!near(data_o, 0)) begin
      bad++;
      $display("FAIL reset_data got=%0d want=0", data_o);
    end
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shapes();
    run_burst(100, 600, 0, 3, 2, 2, 1'b0);
    @(negedge clk);
    run_burst(100, 600, 100, 1, 1, 1, 1'b0);
    @(negedge clk);
    run_burst(0, 1023, 1000, 1, 1, 1, 1'b0);
    @(negedge clk);
    run_burst(800, 200, 150, 2, 1, 2, 1'b0);
    @(negedge clk);
    run_burst(300, 300, 50, 0, 0, 2, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    build_model(50, 700, 0, 5, 2, 2);
    drive_cfg(50, 700, 0, 5, 2, 2);
    start_i = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      total++;
      if (!near(data_o, exp_d[i]) || edge_mark_o !== exp_m[i]) begin
        bad++;
        $display("FAIL abort_pre idx=%0d got=%0d/%b want=%0d/%b",
                 i, data_o, edge_mark_o, exp_d[i], exp_m[i]);
      end
    end
    abort_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    start_i = 1'b0;
    total++;
    if ({data_valid_o, busy_o, done_o, edge_mark_o} !== 4'b0000) begin
      bad++;
      $display("FAIL abort_flags got=%b want=0000",
               {data_valid_o, busy_o, done_o, edge_mark_o});
    end
    total++;
    if (!near(data_o, 50)) begin
      bad++;
      $display("FAIL abort_data got=%0d want=50", data_o);
    end
    run_burst(200, 400, 70, 2, 3, 2, 1'b0);
  endtask

  task automatic test_zero_pulses();
    @(negedge clk);
    drive_cfg(10, 20, 0, 1, 1, 0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    total++;
    if ({data_valid_o, busy_o, done_o, edge_mark_o} !== 4'b0010) begin
      bad++;
      $display("FAIL zero_done got=%b want=0010",
               {data_valid_o, busy_o, done_o, edge_mark_o});
    end
    @(negedge clk);
    total++;
    if ({data_valid_o, busy_o, done_o, edge_mark_o} !== 4'b0000) begin
      bad++;
      $display("FAIL zero_after got=%b want=0000",
               {data_valid_o, busy_o, done_o, edge_mark_o});
    end
  endtask

  task automatic test_busy_start();
    @(negedge clk);
    run_burst(150, 850, 120, 2, 2, 3, 1'b1);
  endtask

  task automatic test_idle();
    @(negedge clk);
    run_burst(120, 900, 0, 1, 1, 1, 1'b0);
    start_i = 1'b1;
    abort_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      poke_cfg();
      total++;
      if ({data_valid_o, busy_o, done_o} !== 3'b000
          || !near(data_o, 120)) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d got=%0d/%b want=120/000",
                 i, data_o, {data_valid_o, busy_o, done_o});
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_cfg(400, 100, 30, 3, 2, 3);
    start_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    total++;
    if ({data_valid_o, busy_o, done_o, edge_mark_o} !== 4'b0000
        || !near(data_o, 0)) begin
      bad++;
      $display("FAIL reset_mid got=%0d/%b want=0/0000", data_o,
               {data_valid_o, busy_o, done_o, edge_mark_o});
    end
    @(negedge clk);
    total++;
    if ({data_valid_o, busy_o, done_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_nodone got=%b want=000",
               {data_valid_o, busy_o, done_o});
    end
  endtask

  task automatic test_back_to_back();
    int lo, hi, st, hl, ll, pn;
    @(negedge clk);
    for (int n = 0; n < 12; n++) begin
      lo = $urandom_range(0, 1023);
      hi = $urandom_range(0, 1023);
      st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(20, 400);
      hl = $urandom_range(0, 4);
      ll = $urandom_range(0, 4);
      pn = $urandom_range(1, 3);
      run_burst(lo, hi, st, hl, ll, pn, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_shapes();
    test_abort();
    test_zero_pulses();
    test_busy_start();
    test_idle();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
